// File: rtl/mips_seq_alu.sv
// Multi-cycle MIPS ALU: valid/ready handshake, 1-bit/cycle shift-add MUL and restoring DIVU.
// Optional signed ADD/SUB overflow flag enabled by defining MIPS_ALU_OVF_EN.
module mips_seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_DIVU = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state_q, state_nx;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] acc_hi_nx, acc_lo_nx;
  logic [CNT_W-1:0] cnt_q;
  logic             iterative, last_step;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] add_res, sub_res, single_res;

  assign iterative = (op_q == OP_MUL) || (op_q == OP_DIVU);
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx  = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (!iterative || last_step) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // One iteration step; MUL and DIVU share the acc_hi/acc_lo pair so the
  // final {acc_hi, acc_lo} maps directly onto {result_hi, result_lo}.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift - {1'b0, b_q};
    if (op_q == OP_MUL) begin
      acc_hi_nx = mul_sum[WIDTH:1];
      acc_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      acc_hi_nx = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      acc_lo_nx = {acc_lo[WIDTH-2:0], div_ge};
    end
  end

  assign add_res = a_q + b_q;
  assign sub_res = a_q - b_q;

  always_comb begin
    single_res = '0;
    case (op_q)
      OP_AND:  single_res = a_q & b_q;
      OP_OR:   single_res = a_q | b_q;
      OP_ADD:  single_res = add_res;
      OP_SUB:  single_res = sub_res;
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: single_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q   <= alu_control;
            a_q    <= src_a;
            b_q    <= src_b;
            cnt_q  <= '0;
            acc_hi <= '0;
            // Multiplier bits are consumed LSB-first, dividend bits MSB-first.
            acc_lo <= (alu_control == OP_MUL) ? src_b : src_a;
          end
        end
        S_EXEC: begin
          if (iterative) begin
            acc_hi <= acc_hi_nx;
            acc_lo <= acc_lo_nx;
            cnt_q  <= cnt_q + 1'b1;
            if (last_step) begin
              result_lo <= acc_lo_nx;
              result_hi <= acc_hi_nx;
            end
          end else begin
            result_lo <= single_res;
            result_hi <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign zero = ~|result_lo;

`ifdef MIPS_ALU_OVF_EN
  logic ovf_q, ovf_nx;

  always_comb begin
    ovf_nx = 1'b0;
    if (op_q == OP_ADD)
      ovf_nx = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);
    else if (op_q == OP_SUB)
      ovf_nx = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_res[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst)                                ovf_q <= 1'b0;
    else if (state_q == S_IDLE && in_valid) ovf_q <= 1'b0;
    else if (state_q == S_EXEC)             ovf_q <= ovf_nx;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mips_seq_alu.sv
// Self-checking bench for mips_seq_alu: directed corner cases plus random ops vs. an arithmetic model.
module tb_mips_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_control;
  logic [W-1:0] src_a, src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result_lo, result_hi;
  logic         zero, overflow;

  int total = 0;
  int bad   = 0;

  mips_seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_lo(result_lo), .result_hi(result_hi),
    .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain wide arithmetic on the operation's meaning.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] lo, output logic [W-1:0] hi,
                       output logic ovf, output int lat);
    longint unsigned ua, ub, prod;
    longint sa, sb, sr;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    hi = '0; ovf = 1'b0; lat = 2; sr = 0;
    case (op)
      3'b000: lo = a & b;
      3'b001: lo = a | b;
      3'b010: begin lo = W'(ua + ub); sr = sa + sb; end
      3'b100: begin lo = W'(ua - ub); sr = sa - sb; end
      3'b110: lo = (ua < ub) ? 1 : 0;
      3'b111: lo = (sa < sb) ? 1 : 0;
      3'b101: begin prod = ua * ub; lo = prod[W-1:0]; hi = prod[2*W-1:W]; lat = W + 1; end
      default: begin
        lat = W + 1;
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = W'(ua / ub); hi = W'(ua % ub); end
      end
    endcase
`ifdef MIPS_ALU_OVF_EN
    if (op == 3'b010 || op == 3'b100)
      ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`endif
  endtask

  // Issue one op, measure latency, hold backpressure for bp cycles, check, then hand off.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int bp);
    logic [W-1:0] elo, ehi;
    logic eovf;
    int elat, lat;
    model(op, a, b, elo, ehi, eovf, elat);
    @(negedge clk);
    check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; alu_control = op; src_a = a; src_b = b; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; src_a = $urandom; src_b = $urandom; alu_control = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready !== 1'b0) begin
        total++; bad++;
        $error("FAIL %s.busy_in_ready observed=%0b expected=0", tag, in_ready);
      end
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(elat));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check({tag, ".held_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".held_in_ready"}, 64'(in_ready), 64'd0);
    end
    check({tag, ".lo"}, 64'(result_lo), 64'(elo));
    check({tag, ".hi"}, 64'(result_hi), 64'(ehi));
    check({tag, ".zero"}, 64'(zero), 64'(elo == 0));
    check({tag, ".ovf"}, 64'(overflow), 64'(eovf));
    // Present a competing op during the handshake cycle; it must not be taken.
    out_ready = 1'b1; in_valid = 1'b1; src_a = $urandom; src_b = $urandom;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".post_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".post_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.lo", 64'(result_lo), 64'd0);
    check("rst.hi", 64'(result_hi), 64'd0);
    check("rst.zero", 64'(zero), 64'd1);
    check("rst.ovf", 64'(overflow), 64'd0);

    run_op("add_7_5", 3'b010, 32'd7, 32'd5, 0);
    run_op("sub_eq", 3'b100, 32'd5, 32'd5, 0);
    run_op("sltu", 3'b110, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("slt", 3'b111, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("and", 3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    run_op("or", 3'b001, 32'hF000_0001, 32'h0000_1000, 0);
    run_op("mul", 3'b101, 32'hFFFF_FFFF, 32'd2, 0);
    run_op("divu", 3'b011, 32'd100, 32'd7, 0);
    run_op("divu0", 3'b011, 32'd9, 32'd0, 0);
    run_op("backpressure", 3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 5);
    run_op("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'd1, 0);
    run_op("sub_ovf", 3'b100, 32'h8000_0000, 32'd1, 0);

    // Reset during MUL iteration 10.
    @(negedge clk);
    in_valid = 1'b1; alu_control = 3'b101; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst.in_ready", 64'(in_ready), 64'd1);
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.lo", 64'(result_lo), 64'd0);
    check("midrst.zero", 64'(zero), 64'd1);
    run_op("after_rst_add", 3'b010, 32'd1, 32'd1, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (n % 5 == 0) rb = 32'($urandom_range(1, 300));
      run_op($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
